// File: rtl/multi_trigger_aligner.sv
// multi_trigger_aligner
// Turns a shared level trigger into per-channel pulses aligned to an
// external alignment strobe (bsync). Each channel arms on a trigger edge,
// waits for bsync_event, delays by (2*ratio - 2 - phase) cycles and then
// emits a pulse of 'ratio' cycles.
//
// Channel FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a trigger edge
//   ST_ARMED | trigger accepted, waiting for the next bsync_event
//   ST_DELAY | counting the latched delay down to the pulse start
//   ST_PULSE | trig_out high, counting the latched width down
module multi_trigger_aligner #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      trigger,
  input  logic                      bsync_event,
  input  logic                      bsync_ready,
  input  logic [PHASE_W-1:0]        bsync_ratio,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         ch_mode,
  input  logic [NUM_CH*PHASE_W-1:0] ch_phase,
  input  logic [NUM_CH-1:0]         missed_clr,
  output logic [NUM_CH-1:0]         trig_out,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH-1:0]         trig_missed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_PULSE = 2'd3
  } state_t;

  localparam int DW = PHASE_W + 2;

  logic               r_trig_d1;
  logic               r_trig_edge;
  logic [DW-1:0]      w_ratio2_m2;
  logic [PHASE_W-1:0] w_width;

  // Trigger rising-edge detector shared by all channels. During reset the
  // delay stage follows the trigger so a level held through reset release
  // is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_trig_d1   <= trigger;
      r_trig_edge <= 1'b0;
    end else begin
      r_trig_d1   <= trigger;
      r_trig_edge <= trigger & ~r_trig_d1;
    end
  end

  // 2*ratio - 2 in DW bits; a zero ratio wraps to a negative value, which the
  // per-channel clamp below turns into a zero delay.
  assign w_ratio2_m2 = {1'b0, bsync_ratio, 1'b0} - DW'(2);

  // A zero ratio still produces a one-cycle pulse.
  assign w_width = (bsync_ratio == '0) ? PHASE_W'(1) : bsync_ratio;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t             r_state;
    logic [PHASE_W-1:0] r_cnt;
    logic [PHASE_W-1:0] r_width;
    logic               r_out;
    logic               r_missed;
    logic [DW-1:0]      w_dly_raw;
    logic [PHASE_W-1:0] w_dly;
    logic               w_abort;

    assign w_dly_raw = w_ratio2_m2 - {2'b00, ch_phase[gi*PHASE_W +: PHASE_W]};

    // Negative results (MSB set) clamp to zero; results that do not fit the
    // counter saturate so the delay never wraps to a short value.
    always_comb begin
      w_dly = w_dly_raw[PHASE_W-1:0];
      if (w_dly_raw[DW-1]) begin
        w_dly = '0;
      end else if (w_dly_raw[PHASE_W]) begin
        w_dly = '1;
      end
    end

    assign w_abort = ~ch_en[gi] | ~bsync_ready;

    // Per-channel sequencer: arm, align, delay, pulse, plus overrun flag.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_width  <= '0;
        r_out    <= 1'b0;
        r_missed <= 1'b0;
      end else begin
        if (r_trig_edge && (r_state != ST_IDLE)) begin
          r_missed <= 1'b1;
        end else if (missed_clr[gi]) begin
          r_missed <= 1'b0;
        end

        if (w_abort) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_out <= 1'b0;
              if (r_trig_edge) begin
                r_state <= ST_ARMED;
              end
            end
            ST_ARMED: begin
              r_out <= 1'b0;
              if (bsync_event) begin
                r_width <= w_width;
                if (w_dly == '0) begin
                  r_state <= ST_PULSE;
                  r_cnt   <= w_width;
                  r_out   <= 1'b1;
                end else begin
                  r_state <= ST_DELAY;
                  r_cnt   <= w_dly;
                end
              end
            end
            ST_DELAY: begin
              if (r_cnt <= PHASE_W'(1)) begin
                r_state <= ST_PULSE;
                r_cnt   <= r_width;
                r_out   <= 1'b1;
              end else begin
                r_cnt <= r_cnt - PHASE_W'(1);
              end
            end
            ST_PULSE: begin
              if (r_cnt <= PHASE_W'(1)) begin
                r_out <= 1'b0;
                r_cnt <= '0;
                r_state <= (ch_mode[gi] && trigger) ? ST_ARMED : ST_IDLE;
              end else begin
                r_cnt <= r_cnt - PHASE_W'(1);
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_out   <= 1'b0;
            end
          endcase
        end
      end
    end

    assign trig_out[gi]    = r_out;
    assign ch_busy[gi]     = (r_state != ST_IDLE);
    assign trig_missed[gi] = r_missed;
  end

endmodule

// File: tb/tb_multi_trigger_aligner.sv
// Randomised and directed bench for multi_trigger_aligner. The reference
// model tracks each channel as a timeline: an armed flag plus the absolute
// cycle numbers at which its pulse window starts and ends.
module tb_multi_trigger_aligner;
  localparam int NUM_CH  = 4;
  localparam int PHASE_W = 16;

  logic                      clk;
  logic                      rstn;
  logic                      trigger;
  logic                      bsync_event;
  logic                      bsync_ready;
  logic [PHASE_W-1:0]        bsync_ratio;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH-1:0]         ch_mode;
  logic [NUM_CH*PHASE_W-1:0] ch_phase;
  logic [NUM_CH-1:0]         missed_clr;
  logic [NUM_CH-1:0]         trig_out;
  logic [NUM_CH-1:0]         ch_busy;
  logic [NUM_CH-1:0]         trig_missed;

  multi_trigger_aligner #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W)) dut (
    .clk(clk), .rstn(rstn), .trigger(trigger), .bsync_event(bsync_event),
    .bsync_ready(bsync_ready), .bsync_ratio(bsync_ratio), .ch_en(ch_en),
    .ch_mode(ch_mode), .ch_phase(ch_phase), .missed_clr(missed_clr),
    .trig_out(trig_out), .ch_busy(ch_busy), .trig_missed(trig_missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  bit m_edge, m_prev;
  bit m_armed  [NUM_CH];
  bit m_win    [NUM_CH];
  bit m_missed [NUM_CH];
  int m_start  [NUM_CH];
  int m_end    [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples.
  task automatic model_step();
    bit edge_now;
    int c;
    cyc++;
    c = cyc - 1;
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_armed[i] = 0; m_win[i] = 0; m_missed[i] = 0;
      end
      m_edge = 0;
      m_prev = trigger;
      return;
    end
    edge_now = m_edge;
    m_edge   = trigger && !m_prev;
    m_prev   = trigger;
    for (int i = 0; i < NUM_CH; i++) begin
      bit idle;
      int d, w, r, p;
      idle = !m_armed[i] && !m_win[i];
      if (edge_now && !idle) m_missed[i] = 1;
      else if (missed_clr[i]) m_missed[i] = 0;
      if (!ch_en[i] || !bsync_ready) begin
        m_armed[i] = 0;
        m_win[i]   = 0;
      end else if (idle) begin
        if (edge_now) m_armed[i] = 1;
      end else if (m_armed[i]) begin
        if (bsync_event) begin
          r = int'(bsync_ratio);
          p = int'(ch_phase[i*PHASE_W +: PHASE_W]);
          d = 2 * r - 2 - p;
          if (d < 0) d = 0;
          if (d > 65535) d = 65535;
          w = (r == 0) ? 1 : r;
          m_armed[i] = 0;
          m_win[i]   = 1;
          m_start[i] = cyc + d;
          m_end[i]   = m_start[i] + w - 1;
        end
      end else if (c == m_end[i]) begin
        m_win[i]   = 0;
        m_armed[i] = ch_mode[i] && trigger;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] e_out, e_busy, e_miss;
    for (int i = 0; i < NUM_CH; i++) begin
      e_out[i]  = m_win[i] && (cyc >= m_start[i]) && (cyc <= m_end[i]);
      e_busy[i] = m_armed[i] || m_win[i];
      e_miss[i] = m_missed[i];
    end
    check("trig_out", 32'(trig_out), 32'(e_out));
    check("ch_busy", 32'(ch_busy), 32'(e_busy));
    check("trig_missed", 32'(trig_missed), 32'(e_miss));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_phase(input int ch, input int val);
    ch_phase[ch*PHASE_W +: PHASE_W] = PHASE_W'(val);
  endtask

  // Fresh trigger edge, let the channel arm, then one bsync_event (cycle T).
  // Returns at the sampling point of cycle T+1.
  task automatic arm_and_fire();
    trigger = 1'b0;
    cycle();
    trigger = 1'b1;
    repeat (3) cycle();
    bsync_event = 1'b1;
    cycle();
    bsync_event = 1'b0;
  endtask

  // first: offset k (T+k) of the first high sample, cnt: number of high cycles
  task automatic measure(input int ch, input int ncyc, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (trig_out[ch]) begin
        if (first < 0) first = k;
        cnt++;
      end
      cycle();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt, pulses;
    logic prev_o;
    rstn = 1'b0; trigger = 1'b1; bsync_event = 1'b0; bsync_ready = 1'b1;
    bsync_ratio = 16'd8; ch_en = 4'b0001; ch_mode = 4'b0000;
    ch_phase = '0; missed_clr = '0;
    set_phase(0, 4);
    repeat (3) cycle();
    check("rst_out", 32'(trig_out), 32'd0);
    check("rst_busy", 32'(ch_busy), 32'd0);
    rstn = 1'b1;
    // trigger held high through reset release must not arm
    repeat (5) cycle();
    check("held_trig_busy", 32'(ch_busy), 32'd0);

    // basic alignment: D = 16-2-4 = 10, pulse T+11..T+18
    arm_and_fire();
    measure(0, 30, first, cnt);
    check("basic_first", 32'(first), 32'd11);
    check("basic_width", 32'(cnt), 32'd8);
    check("basic_others", 32'(trig_out[3:1]), 32'd0);

    // clamp: phase 20 -> D = 0, pulse T+1..T+8
    set_phase(0, 20);
    arm_and_fire();
    measure(0, 20, first, cnt);
    check("clamp_first", 32'(first), 32'd1);
    check("clamp_width", 32'(cnt), 32'd8);

    // ratio 0 -> single-cycle pulse at T+1
    bsync_ratio = 16'd0;
    arm_and_fire();
    measure(0, 10, first, cnt);
    check("zero_first", 32'(first), 32'd1);
    check("zero_width", 32'(cnt), 32'd1);

    // repeat mode on channel 1, trigger dropped during the third pulse
    ch_en = 4'b0010; ch_mode = 4'b0010; bsync_ratio = 16'd4; set_phase(1, 0);
    trigger = 1'b0;
    cycle();
    trigger = 1'b1;
    repeat (3) cycle();
    pulses = 0;
    prev_o = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (trig_out[1] && !prev_o) pulses++;
      prev_o = trig_out[1];
      if (pulses == 3) trigger = 1'b0;
      bsync_event = (k % 8 == 0);
      cycle();
    end
    bsync_event = 1'b0;
    check("repeat_pulses", 32'(pulses), 32'd3);
    check("repeat_idle", 32'(ch_busy[1]), 32'd0);

    // overrun on channel 2 while in DELAY (D = 14)
    ch_en = 4'b0100; ch_mode = 4'b0000; bsync_ratio = 16'd8; set_phase(2, 0);
    arm_and_fire();
    trigger = 1'b0;
    cycle();
    trigger = 1'b1;
    cycle();
    cycle();
    check("overrun_set", 32'(trig_missed[2]), 32'd1);
    missed_clr = 4'b0100;
    cycle();
    missed_clr = 4'b0000;
    check("overrun_clr", 32'(trig_missed[2]), 32'd0);
    trigger = 1'b0;
    cycle();
    trigger = 1'b1;
    cycle();
    missed_clr = 4'b0100;
    cycle();
    missed_clr = 4'b0000;
    check("overrun_set_wins", 32'(trig_missed[2]), 32'd1);
    measure(2, 30, first, cnt);
    check("overrun_one_pulse", 32'(cnt), 32'd8);

    // abort: bsync_ready dropped in the third pulse cycle
    ch_en = 4'b0001; set_phase(0, 20);
    arm_and_fire();
    cycle();
    cycle();
    check("abort_pre", 32'(trig_out[0]), 32'd1);
    bsync_ready = 1'b0;
    cycle();
    check("abort_out", 32'(trig_out[0]), 32'd0);
    check("abort_busy", 32'(ch_busy[0]), 32'd0);
    bsync_ready = 1'b1;
    cycle();

    // reset mid-DELAY on channel 2
    ch_en = 4'b0100;
    arm_and_fire();
    repeat (3) cycle();
    check("rstdly_busy", 32'(ch_busy[2]), 32'd1);
    rstn = 1'b0;
    cycle();
    check("rstdly_out", 32'(trig_out), 32'd0);
    check("rstdly_busyz", 32'(ch_busy), 32'd0);
    check("rstdly_miss", 32'(trig_missed), 32'd0);
    rstn = 1'b1;
    cycle();

    // randomised traffic
    ch_en = 4'b1111; ch_mode = 4'($urandom_range(15));
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) < 10) trigger = ~trigger;
      bsync_event = ($urandom_range(99) < 12);
      if (bsync_ready) begin
        if ($urandom_range(99) < 2) bsync_ready = 1'b0;
      end else if ($urandom_range(99) < 30) bsync_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_en[i]) begin
          if ($urandom_range(99) < 1) ch_en[i] = 1'b0;
        end else if ($urandom_range(99) < 20) ch_en[i] = 1'b1;
        missed_clr[i] = ($urandom_range(99) < 5);
        if ($urandom_range(99) < 3) set_phase(i, int'($urandom_range(20)));
      end
      if ($urandom_range(99) < 3) bsync_ratio = 16'($urandom_range(10));
      if ($urandom_range(99) < 3) ch_mode = 4'($urandom_range(15));
      rstn = !($urandom_range(999) < 3);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
